// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter: two one-entry holding registers share the single
// register-file write port through a registered output stage, and report in-flight targets.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              ctrl_reset,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_reg,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_reg,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              ctrl_writeEnable,
   output logic [ADDR_W-1:0] ctrl_writeReg,
   output logic [DATA_W-1:0] data_writeReg,
   output logic              grant_id,
   output logic [31:0]       busy_mask
);

   logic              hold0Full;
   logic [ADDR_W-1:0] hold0Reg;
   logic [DATA_W-1:0] hold0Data;
   logic              hold1Full;
   logic [ADDR_W-1:0] hold1Reg;
   logic [DATA_W-1:0] hold1Data;
   logic              lastGrant;
   logic              grant0;
   logic              grant1;
   logic              accept0;
   logic              accept1;

   // Arbitration looks only at the holds, so a new request never bypasses a waiting one;
   // on a tie the requester that did not win last time goes first.
   always_comb begin
      grant0     = hold0Full && (!hold1Full || lastGrant);
      grant1     = hold1Full && (!hold0Full || !lastGrant);
      req0_ready = !ctrl_reset && (!hold0Full || grant0);
      req1_ready = !ctrl_reset && (!hold1Full || grant1);
      accept0    = req0_valid && req0_ready;
      accept1    = req1_valid && req1_ready;
   end

   // A granted hold drains into the output stage on the same edge it may be refilled;
   // writes to register 0 are accepted but never stored, so they can never reach the regfile.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         hold0Full        <= 1'b0;
         hold0Reg         <= '0;
         hold0Data        <= '0;
         hold1Full        <= 1'b0;
         hold1Reg         <= '0;
         hold1Data        <= '0;
         lastGrant        <= 1'b1;
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= '0;
         data_writeReg    <= '0;
         grant_id         <= 1'b0;
      end else begin
         if (grant0) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= hold0Reg;
            data_writeReg    <= hold0Data;
            grant_id         <= 1'b0;
            lastGrant        <= 1'b0;
            hold0Full        <= 1'b0;
         end else if (grant1) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= hold1Reg;
            data_writeReg    <= hold1Data;
            grant_id         <= 1'b1;
            lastGrant        <= 1'b1;
            hold1Full        <= 1'b0;
         end else begin
            ctrl_writeEnable <= 1'b0;
         end

         if (accept0 && (req0_reg != '0)) begin
            hold0Full <= 1'b1;
            hold0Reg  <= req0_reg;
            hold0Data <= req0_data;
         end
         if (accept1 && (req1_reg != '0)) begin
            hold1Full <= 1'b1;
            hold1Reg  <= req1_reg;
            hold1Data <= req1_data;
         end
      end
   end

   // Decode's view of pending writes: anything sitting in a hold or on the output port.
   always_comb begin
      busy_mask = '0;
      for (int i = 1; i < 32; i++) begin
         busy_mask[i] = (hold0Full && (hold0Reg == ADDR_W'(i)))
                     || (hold1Full && (hold1Reg == ADDR_W'(i)))
                     || (ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(i)));
      end
   end

endmodule
